// File: rtl/video_pkg.sv
// Shared constants and types for the 720p test-pattern path: raster
// geometry, the colour palette and the pattern selector encoding.
package video_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_TOTAL_720P  = 1650;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_TOTAL_720P  = 750;

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BLACK   = 24'h000000;
  localparam logic [23:0] GREY25  = 24'h404040;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] BLUE    = 24'h0000FF;

  typedef enum logic [1:0] {
    PAT_BARS   = 2'd0,
    PAT_CHECK  = 2'd1,
    PAT_GRAD   = 2'd2,
    PAT_BORDER = 2'd3
  } patMode_e;

  // Classic SMPTE-style order, brightest on the left.
  function automatic logic [23:0] barColour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_raster_pos.sv
// First pipeline stage: rebuilds the pixel position from the raw timing
// strobes, tracks the colour-bar index without a divider, and latches the
// pattern mode and frame counter at each frame start.
module video_raster_pos
  import video_pkg::*;
#(
  parameter int H_ACTIVE         = 1280,
  parameter int V_ACTIVE         = 720,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1,
  parameter int XW               = $clog2(H_ACTIVE),
  parameter int YW               = $clog2(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync_i,
  input  logic          visible_i,
  input  logic [1:0]    mode_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [2:0]    bar_o,
  output patMode_e      activeMode_o,
  output logic [7:0]    frameCount_o
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic          vsActive;
  logic          frameStart;
  logic          visFall;
  logic          vsPrev_q, vsPrev_d;
  logic          visPrev_q, visPrev_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] barCnt_q, barCnt_d;
  logic [2:0]    bar_q, bar_d;
  patMode_e      mode_q, mode_d;
  logic [7:0]    frameCount_q, frameCount_d;

  // Normalise vsync polarity and find the frame-start and end-of-line edges.
  always_comb begin
    vsActive   = (vsync_i == SYNC_ACTIVE_HIGH);
    frameStart = vsActive && !vsPrev_q;
    visFall    = !visible_i && visPrev_q;
  end

  // Next position: x and the bar tracker restart on each visible run and
  // freeze at the last column; frame start overrides the line advance.
  always_comb begin
    vsPrev_d     = vsActive;
    visPrev_d    = visible_i;
    x_d          = '0;
    barCnt_d     = '0;
    bar_d        = '0;
    y_d          = y_q;
    mode_d       = mode_q;
    frameCount_d = frameCount_q;
    if (visible_i && visPrev_q) begin
      x_d      = x_q;
      barCnt_d = barCnt_q;
      bar_d    = bar_q;
      if (x_q != X_LAST) begin
        x_d = x_q + 1'b1;
        if (barCnt_q == BAR_LAST) begin
          barCnt_d = '0;
          bar_d    = bar_q + 1'b1;
        end else begin
          barCnt_d = barCnt_q + 1'b1;
        end
      end
    end
    if (frameStart) begin
      y_d          = '0;
      mode_d       = patMode_e'(mode_i);
      frameCount_d = frameCount_q + 8'd1;
    end else if (visFall && (y_q != Y_LAST)) begin
      y_d = y_q + 1'b1;
    end
  end

  // Stage-1 state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsPrev_q     <= 1'b0;
      visPrev_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      barCnt_q     <= '0;
      bar_q        <= '0;
      mode_q       <= PAT_BARS;
      frameCount_q <= '0;
    end else begin
      vsPrev_q     <= vsPrev_d;
      visPrev_q    <= visPrev_d;
      x_q          <= x_d;
      y_q          <= y_d;
      barCnt_q     <= barCnt_d;
      bar_q        <= bar_d;
      mode_q       <= mode_d;
      frameCount_q <= frameCount_d;
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign bar_o        = bar_q;
  assign activeMode_o = mode_q;
  assign frameCount_o = frameCount_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern pixel source: two-stage pipeline turning the timing
// generator strobes into RGB plus syncs and DE delayed to stay aligned.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE         = 1280,
  parameter int V_ACTIVE         = 720,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1,
  parameter int CHECK_SHIFT      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       visible_in,
  input  logic [1:0] mode,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic [7:0] frame_count
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE_HIGH;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0] posX;
  logic [YW-1:0] posY;
  logic [2:0]    barIdx;
  patMode_e      activeMode;
  logic [7:0]    frameCount;
  logic [23:0]   pixel;

  logic        hsS1_q, hsS1_d;
  logic        vsS1_q, vsS1_d;
  logic        deS1_q, deS1_d;
  logic        hsOut_q, hsOut_d;
  logic        vsOut_q, vsOut_d;
  logic        deOut_q, deOut_d;
  logic [23:0] rgbOut_q, rgbOut_d;

  video_raster_pos #(
    .H_ACTIVE         (H_ACTIVE),
    .V_ACTIVE         (V_ACTIVE),
    .SYNC_ACTIVE_HIGH (SYNC_ACTIVE_HIGH),
    .XW               (XW),
    .YW               (YW)
  ) u_raster (
    .clk          (clk),
    .reset        (reset),
    .vsync_i      (vsync_in),
    .visible_i    (visible_in),
    .mode_i       (mode),
    .x_o          (posX),
    .y_o          (posY),
    .bar_o        (barIdx),
    .activeMode_o (activeMode),
    .frameCount_o (frameCount)
  );

  // Colour for the stage-1 pixel according to the mode latched at frame start.
  always_comb begin
    pixel = BLACK;
    case (activeMode)
      PAT_BARS:  pixel = barColour(barIdx);
      PAT_CHECK: pixel = (posX[CHECK_SHIFT] ^ posY[CHECK_SHIFT]) ? WHITE : BLACK;
      PAT_GRAD:  pixel = {8'(posX), 8'(posY), frameCount};
      PAT_BORDER: begin
        if ((posX == '0) || (posX == X_LAST) || (posY == '0) || (posY == Y_LAST)) begin
          pixel = WHITE;
        end else begin
          pixel = GREY25;
        end
      end
      default:   pixel = BLACK;
    endcase
  end

  // Both pipeline stages: timing strobes ride alongside, colour blanked outside DE.
  always_comb begin
    hsS1_d   = hsync_in;
    vsS1_d   = vsync_in;
    deS1_d   = visible_in;
    hsOut_d  = hsS1_q;
    vsOut_d  = vsS1_q;
    deOut_d  = deS1_q;
    rgbOut_d = deS1_q ? pixel : BLACK;
  end

  // Pipeline registers; syncs clear to their idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsS1_q   <= SYNC_IDLE;
      vsS1_q   <= SYNC_IDLE;
      deS1_q   <= 1'b0;
      hsOut_q  <= SYNC_IDLE;
      vsOut_q  <= SYNC_IDLE;
      deOut_q  <= 1'b0;
      rgbOut_q <= '0;
    end else begin
      hsS1_q   <= hsS1_d;
      vsS1_q   <= vsS1_d;
      deS1_q   <= deS1_d;
      hsOut_q  <= hsOut_d;
      vsOut_q  <= vsOut_d;
      deOut_q  <= deOut_d;
      rgbOut_q <= rgbOut_d;
    end
  end

  assign hsync_out   = hsOut_q;
  assign vsync_out   = vsOut_q;
  assign de_out      = deOut_q;
  assign r           = rgbOut_q[23:16];
  assign g           = rgbOut_q[15:8];
  assign b           = rgbOut_q[7:0];
  assign frame_count = frameCount;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a shortened raster (full 1280-pixel lines,
// 48 active lines): every driven cycle queues its expected output, which is
// checked two clocks later.
module tb_video_pattern_gen;

  localparam int HA = 1280;
  localparam int VA = 48;

  logic       clk;
  logic       reset;
  logic       hsync_in;
  logic       vsync_in;
  logic       visible_in;
  logic [1:0] mode;
  logic       hsync_out;
  logic       vsync_out;
  logic       de_out;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic [7:0] frame_count;

  video_pattern_gen #(
    .H_ACTIVE         (HA),
    .V_ACTIVE         (VA),
    .SYNC_ACTIVE_HIGH (1'b1),
    .CHECK_SHIFT      (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .visible_in  (visible_in),
    .mode        (mode),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .de_out      (de_out),
    .r           (r),
    .g           (g),
    .b           (b),
    .frame_count (frame_count)
  );

  // Free-running pixel clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic        pv;
    logic [23:0] prgb;
    string       ptag;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          mX, mY, mMode, mFc;
  logic        mVsPrev, mVisPrev;
  int          probeX[$];
  logic [23:0] probeRgb[$];
  string       probeTag[$];

  function automatic logic [23:0] expColour(input int md, input int x, input int y, input int fc);
    logic [23:0] c;
    case (md)
      0: begin
        case (x / 160)
          0:       c = 24'hFFFFFF;
          1:       c = 24'hFFFF00;
          2:       c = 24'h00FFFF;
          3:       c = 24'h00FF00;
          4:       c = 24'hFF00FF;
          5:       c = 24'hFF0000;
          6:       c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      1:       c = ((((x >> 5) ^ (y >> 5)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
      2:       c = {8'(x), 8'(y), 8'(fc)};
      default: c = ((x == 0) || (x == HA - 1) || (y == 0) || (y == VA - 1)) ? 24'hFFFFFF : 24'h404040;
    endcase
    return c;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkVal("hsync_out", 32'(hsync_out), 32'(e.hs));
    checkVal("vsync_out", 32'(vsync_out), 32'(e.vs));
    checkVal("de_out", 32'(de_out), 32'(e.de));
    checkVal("rgb", 32'({r, g, b}), 32'(e.rgb));
    if (e.pv) checkVal(e.ptag, 32'({r, g, b}), 32'(e.prgb));
  endtask

  // One pixel clock: drive inputs, queue what must emerge two clocks later,
  // then check the entry that is due now.
  task automatic applyStimulus(input logic rst, input logic hs, input logic vs,
                               input logic vis, input int pIdx);
    exp_t e;
    exp_t got;
    logic fs;
    logic fall;
    reset      = rst;
    hsync_in   = hs;
    vsync_in   = vs;
    visible_in = vis;
    e.hs = 1'b0; e.vs = 1'b0; e.de = 1'b0; e.rgb = '0;
    e.pv = 1'b0; e.prgb = '0; e.ptag = "";
    if (rst) begin
      mX = 0; mY = 0; mMode = 0; mFc = 0;
      mVsPrev = 1'b0; mVisPrev = 1'b0;
      if (sb.size() > 0) sb[sb.size() - 1] = e;
    end else begin
      fs   = vs && !mVsPrev;
      fall = !vis && mVisPrev;
      if (fs) begin
        mFc   = (mFc + 1) % 256;
        mMode = int'(mode);
      end
      if (vis) mX = mVisPrev ? ((mX < HA - 1) ? mX + 1 : HA - 1) : 0;
      else     mX = 0;
      if (fs) mY = 0;
      else if (fall && (mY < VA - 1)) mY = mY + 1;
      mVsPrev  = vs;
      mVisPrev = vis;
      e.hs  = hs;
      e.vs  = vs;
      e.de  = vis;
      e.rgb = vis ? expColour(mMode, mX, mY, mFc) : 24'h000000;
      if (pIdx >= 0) begin
        e.pv   = 1'b1;
        e.prgb = probeRgb[pIdx];
        e.ptag = probeTag[pIdx];
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput(got);
    checkVal("frame_count", 32'(frame_count), 32'(mFc));
  endtask

  task automatic addProbe(input int x, input logic [23:0] rgb, input string tag);
    probeX.push_back(x);
    probeRgb.push_back(rgb);
    probeTag.push_back(tag);
  endtask

  // Line: 8 hsync cycles, 8 back porch, nVis visible pixels, 8 front porch.
  task automatic driveLine(input int nVis, input logic vs, input int rstCycle);
    int len;
    len = 24 + nVis;
    for (int c = 0; c < len; c++) begin
      logic vis;
      int   pIdx;
      vis  = (c >= 16) && (c < 16 + nVis);
      pIdx = -1;
      if (vis) begin
        for (int i = 0; i < probeX.size(); i++) begin
          if (probeX[i] == c - 16) pIdx = i;
        end
      end
      applyStimulus(c == rstCycle, c < 8, vs, vis, pIdx);
    end
    probeX.delete();
    probeRgb.delete();
    probeTag.delete();
  endtask

  task automatic shortLines(input int first, input int last);
    for (int l = first; l <= last; l++) driveLine(4, 1'b0, -1);
  endtask

  initial begin
    exp_t idle;
    idle.hs = 1'b0; idle.vs = 1'b0; idle.de = 1'b0; idle.rgb = '0;
    idle.pv = 1'b0; idle.prgb = '0; idle.ptag = "";
    sb.push_back(idle);
    mX = 0; mY = 0; mMode = 0; mFc = 0; mVsPrev = 1'b0; mVisPrev = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      mode = 2'($urandom_range(0, 3));
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
    end
    mode = 2'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, -1);
    checkVal("reset_rgb", 32'({r, g, b}), 32'h0);
    checkVal("reset_de", 32'(de_out), 32'h0);
    checkVal("reset_hs", 32'(hsync_out), 32'h0);
    checkVal("reset_vs", 32'(vsync_out), 32'h0);
    checkVal("reset_fc", 32'(frame_count), 32'h0);

    // Frame 1: colour bars.
    driveLine(0, 1'b1, -1);
    checkVal("fc_first_frame", 32'(frame_count), 32'd1);
    addProbe(0, 24'hFFFFFF, "bar_px0");
    addProbe(159, 24'hFFFFFF, "bar_px159");
    addProbe(160, 24'hFFFF00, "bar_px160");
    addProbe(1279, 24'h000000, "bar_px1279");
    driveLine(HA, 1'b0, -1);
    shortLines(1, VA - 1);

    // Frame 2: checkerboard.
    mode = 2'd1;
    driveLine(0, 1'b1, -1);
    addProbe(31, 24'h000000, "chk_31_0");
    addProbe(32, 24'hFFFFFF, "chk_32_0");
    driveLine(40, 1'b0, -1);
    shortLines(1, 31);
    addProbe(32, 24'h000000, "chk_32_32");
    driveLine(40, 1'b0, -1);
    shortLines(33, VA - 1);

    // Frame 3: gradient.
    mode = 2'd2;
    driveLine(0, 1'b1, -1);
    shortLines(0, 4);
    addProbe(300, 24'h2C0503, "grad_300_5");
    driveLine(320, 1'b0, -1);
    shortLines(6, VA - 1);

    // Frame 4: border, including an over-long run and an extra line.
    mode = 2'd3;
    driveLine(0, 1'b1, -1);
    shortLines(0, 19);
    addProbe(0, 24'hFFFFFF, "border_left");
    addProbe(1279, 24'hFFFFFF, "border_right");
    addProbe(1285, 24'hFFFFFF, "col_repeat");
    driveLine(1290, 1'b0, -1);
    shortLines(21, 23);
    addProbe(640, 24'h404040, "border_inner");
    driveLine(700, 1'b0, -1);
    shortLines(25, VA - 2);
    addProbe(640, 24'hFFFFFF, "border_bottom");
    driveLine(700, 1'b0, -1);
    addProbe(640, 24'hFFFFFF, "row_repeat");
    driveLine(700, 1'b0, -1);

    // Frame 5: bars, mode switched mid-frame.
    mode = 2'd0;
    driveLine(0, 1'b1, -1);
    shortLines(0, 19);
    mode = 2'd1;
    addProbe(200, 24'hFFFF00, "switch_still_bars");
    driveLine(210, 1'b0, -1);
    shortLines(21, VA - 1);

    // Frame 6: the switched mode takes effect.
    driveLine(0, 1'b1, -1);
    addProbe(32, 24'hFFFFFF, "next_frame_checker");
    driveLine(40, 1'b0, -1);
    shortLines(1, 3);

    // Frame 7: reset pulse in the blanking of line 30.
    mode = 2'd2;
    driveLine(0, 1'b1, -1);
    shortLines(0, 29);
    addProbe(160, 24'hFFFF00, "post_reset_bar");
    driveLine(170, 1'b0, 2);
    checkVal("fc_after_reset", 32'(frame_count), 32'd0);
    shortLines(31, 35);

    // Frame 8: first vsync after the reset.
    mode = 2'd3;
    driveLine(0, 1'b1, -1);
    checkVal("fc_after_vsync", 32'(frame_count), 32'd1);
    addProbe(640, 24'hFFFFFF, "post_reset_border");
    driveLine(650, 1'b0, -1);

    // Frame counter wrap: 255 more vsync pulses bring 1 round to 0.
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, -1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, -1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, -1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, -1);
    end
    checkVal("fc_wrap", 32'(frame_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
